// File: rtl/line_buff_pkg.sv
// Shared timing/tile constants and types for the tiled VGA line buffer.
package line_buff_pkg;

    localparam int WIDTH_PX          = 640;
    localparam int HEIGHT_LNS        = 480;
    localparam int H_B_PORCH_MAX_PX  = 144;
    localparam int V_B_PORCH_MAX_LNS = 35;
    localparam int TILE_WIDTH        = 4;
    localparam int TILE_PER_LINE     = 160;
    localparam int TILE_CTR_WIDTH    = 8;
    localparam int TILES_PER_ROW     = 5;
    localparam int COLR_PXL_WIDTH    = 12;
    localparam int PXL_CTR_WIDTH     = 10;
    localparam int LN_CTR_WIDTH      = 10;
    localparam int FBUFF_DEPTH       = 3840;
    localparam int FBUFF_ADDR_WIDTH  = 12;
    localparam int FBUFF_DATA_WIDTH  = TILES_PER_ROW * COLR_PXL_WIDTH;

    localparam int TILE_SHIFT     = $clog2(TILE_WIDTH);
    localparam int WORDS_PER_ROW  = TILE_PER_LINE / TILES_PER_ROW;
    localparam int WORD_CTR_WIDTH = $clog2(WORDS_PER_ROW);

    typedef logic [COLR_PXL_WIDTH-1:0] pxl_t;
    typedef logic [TILE_CTR_WIDTH-1:0] tile_idx_t;

    typedef enum logic [1:0] {
        FE_IDLE,
        FE_FILL,
        FE_DRAIN
    } fill_st_e;

    localparam logic [PXL_CTR_WIDTH-1:0] H_VIS_FIRST =
        PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX);
    localparam logic [PXL_CTR_WIDTH-1:0] H_VIS_END =
        PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX + WIDTH_PX);
    localparam logic [LN_CTR_WIDTH-1:0] V_VIS_FIRST =
        LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS);
    localparam logic [LN_CTR_WIDTH-1:0] V_VIS_END =
        LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS + HEIGHT_LNS);
    localparam tile_idx_t H_VIS_FIRST_TILE =
        TILE_CTR_WIDTH'(H_B_PORCH_MAX_PX / TILE_WIDTH);
    localparam logic [FBUFF_ADDR_WIDTH-1:0] FBUFF_LAST =
        FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);
    localparam logic [WORD_CTR_WIDTH-1:0] WORD_LAST =
        WORD_CTR_WIDTH'(WORDS_PER_ROW - 1);

    function automatic tile_idx_t tile_base(
        input logic [WORD_CTR_WIDTH-1:0] k
    );
        return tile_idx_t'(k) * TILE_CTR_WIDTH'(TILES_PER_ROW);
    endfunction

endpackage

// File: rtl/line_buff_sys_ctrl.sv
// Line-buffer control: frame pre-fill, ping-pong switch, fill requests, tile index.
// Exposes a visibility flag when LB_BLANK_OUTPUT_EN is defined.
module lb_ctrl
    import line_buff_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [PXL_CTR_WIDTH-1:0] pxl_cntr_i,
    input  logic [LN_CTR_WIDTH-1:0]  ln_cntr_i,
    input  logic [1:0]               fill_done,
    output logic [1:0]               buff_sel,
    output logic [1:0]               fill_req,
    output tile_idx_t                disp_pxl_id,
`ifdef LB_BLANK_OUTPUT_EN
    output logic                     disp_vis,
`endif
    output logic                     frame_start
);

    logic                  h_vis;
    logic                  v_vis;
    logic                  do_switch;
    logic [TILE_SHIFT-1:0] ln_phase;
    logic [1:0]            sel_nxt;
    logic [1:0]            req_nxt;

    assign h_vis = (pxl_cntr_i >= H_VIS_FIRST) && (pxl_cntr_i < H_VIS_END);
    assign v_vis = (ln_cntr_i >= V_VIS_FIRST) && (ln_cntr_i < V_VIS_END);

    assign ln_phase = ln_cntr_i[TILE_SHIFT-1:0]
                    - V_VIS_FIRST[TILE_SHIFT-1:0];

    assign frame_start = (ln_cntr_i == '0) && (pxl_cntr_i == '0);

    // first visible line is served by the pre-fill, so it never switches
    assign do_switch = v_vis && (pxl_cntr_i == '0)
                    && (ln_phase == '0)
                    && (ln_cntr_i != V_VIS_FIRST);

    assign disp_pxl_id = h_vis
        ? (pxl_cntr_i[PXL_CTR_WIDTH-1:TILE_SHIFT] - H_VIS_FIRST_TILE)
        : '0;

`ifdef LB_BLANK_OUTPUT_EN
    assign disp_vis = h_vis && v_vis;
`endif

    always_comb begin
        sel_nxt = buff_sel;
        req_nxt = fill_req & ~fill_done;
        unique case (1'b1)
            frame_start: begin
                sel_nxt = 2'b01;
                req_nxt = 2'b11;
            end
            do_switch: begin
                sel_nxt = {buff_sel[0], buff_sel[1]};
                req_nxt = req_nxt | buff_sel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buff_sel <= 2'b01;
            fill_req <= 2'b00;
        end else begin
            buff_sel <= sel_nxt;
            fill_req <= req_nxt;
        end
    end

endmodule

// File: rtl/line_buff_sys.sv
// Tiled VGA pixel fetch: ping-pong line buffers filled from external BRAM.
// Define LB_BLANK_OUTPUT_EN to zero the output outside the visible area.
module line_buff_sys
    import line_buff_pkg::*;
(
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [PXL_CTR_WIDTH-1:0]    pxl_cntr_i,
    input  logic [LN_CTR_WIDTH-1:0]     ln_cntr_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    output logic                        fbuff_en_o,
    output logic [COLR_PXL_WIDTH-1:0]   disp_pxl_o
);

    logic [1:0] buff_sel;
    logic [1:0] fill_req;
    logic [1:0] fill_done;
    tile_idx_t  disp_pxl_id;
    logic       frame_start;
`ifdef LB_BLANK_OUTPUT_EN
    logic       disp_vis;
`endif

    lb_ctrl u_ctrl (
        .clk         (clk),
        .rstn        (rstn),
        .pxl_cntr_i  (pxl_cntr_i),
        .ln_cntr_i   (ln_cntr_i),
        .fill_done   (fill_done),
        .buff_sel    (buff_sel),
        .fill_req    (fill_req),
        .disp_pxl_id (disp_pxl_id),
`ifdef LB_BLANK_OUTPUT_EN
        .disp_vis    (disp_vis),
`endif
        .frame_start (frame_start)
    );

    fill_st_e                    state;
    fill_st_e                    state_nxt;
    logic                        cur_buf;
    logic                        cur_buf_nxt;
    logic [WORD_CTR_WIDTH-1:0]   rd_cnt;
    logic [WORD_CTR_WIDTH-1:0]   rd_cnt_nxt;
    logic [FBUFF_ADDR_WIDTH-1:0] ptr;
    logic [FBUFF_ADDR_WIDTH-1:0] ptr_nxt;
    logic                        rd_en;

    logic                        wr_vld;
    logic [WORD_CTR_WIDTH-1:0]   wr_k;
    logic                        wr_buf;
    logic                        wr_last;
    tile_idx_t                   wr_base;

    pxl_t buff0 [TILE_PER_LINE];
    pxl_t buff1 [TILE_PER_LINE];
    pxl_t rd_pxl;

    always_comb begin
        state_nxt   = state;
        cur_buf_nxt = cur_buf;
        rd_cnt_nxt  = rd_cnt;
        ptr_nxt     = ptr;
        rd_en       = 1'b0;
        unique case (state)
            FE_IDLE: begin
                if (fill_req != 2'b00) begin
                    state_nxt   = FE_FILL;
                    cur_buf_nxt = ~fill_req[0];
                    rd_cnt_nxt  = '0;
                end
            end
            FE_FILL: begin
                rd_en      = 1'b1;
                rd_cnt_nxt = rd_cnt + 1'b1;
                ptr_nxt    = (ptr == FBUFF_LAST) ? '0 : ptr + 1'b1;
                if (rd_cnt == WORD_LAST)
                    state_nxt = FE_DRAIN;
            end
            // last word lands here; request drops before IDLE samples it
            FE_DRAIN: state_nxt = FE_IDLE;
            default:  state_nxt = FE_IDLE;
        endcase
        if (frame_start)
            ptr_nxt = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= FE_IDLE;
            cur_buf <= 1'b0;
            rd_cnt  <= '0;
            ptr     <= '0;
            wr_vld  <= 1'b0;
            wr_k    <= '0;
            wr_buf  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_buf <= cur_buf_nxt;
            rd_cnt  <= rd_cnt_nxt;
            ptr     <= ptr_nxt;
            wr_vld  <= rd_en;
            wr_k    <= rd_cnt;
            wr_buf  <= cur_buf;
        end
    end

    assign fbuff_en_o   = rd_en;
    assign fbuff_addr_o = ptr;

    assign wr_last   = wr_vld && (wr_k == WORD_LAST);
    assign fill_done = {wr_last && wr_buf, wr_last && !wr_buf};
    assign wr_base   = tile_base(wr_k);

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            for (int j = 0; j < TILES_PER_ROW; j++) begin
                if (wr_buf)
                    buff1[wr_base + tile_idx_t'(j)] <=
                        fbuff_data_i[j*COLR_PXL_WIDTH +: COLR_PXL_WIDTH];
                else
                    buff0[wr_base + tile_idx_t'(j)] <=
                        fbuff_data_i[j*COLR_PXL_WIDTH +: COLR_PXL_WIDTH];
            end
        end
    end

    assign rd_pxl = buff_sel[0] ? buff0[disp_pxl_id] : buff1[disp_pxl_id];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_pxl_o <= '0;
        end else begin
`ifdef LB_BLANK_OUTPUT_EN
            disp_pxl_o <= disp_vis ? rd_pxl : '0;
`else
            disp_pxl_o <= rd_pxl;
`endif
        end
    end

endmodule

// File: tb/tb_line_buff_sys.sv
// Scoreboard bench for line_buff_sys: BRAM reads, fill completions, pixels.
module tb_line_buff_sys;
    import line_buff_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  pxl;
    logic [9:0]  ln;
    logic [59:0] fdata;
    logic [11:0] faddr;
    logic        fen;
    logic [11:0] disp;

    line_buff_sys dut (
        .clk          (clk),
        .rstn         (rstn),
        .pxl_cntr_i   (pxl),
        .ln_cntr_i    (ln),
        .fbuff_data_i (fdata),
        .fbuff_addr_o (faddr),
        .fbuff_en_o   (fen),
        .disp_pxl_o   (disp)
    );

    always #5 clk = ~clk;

`ifdef LB_BLANK_OUTPUT_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    function automatic logic [59:0] word_of(input logic [11:0] a);
        logic [3:0] n;
        n = a[3:0];
        return {5{{3{n}}}};
    endfunction

    function automatic logic [11:0] exp_pxl(input int row, input int tile);
        int         w;
        logic [3:0] n;
        w = (row * 32 + tile / 5) % 3840;
        n = 4'(w);
        return {3{n}};
    endfunction

    always @(posedge clk)
        if (fen) fdata <= word_of(faddr);

    int vecs = 0;
    int errs = 0;

    logic [11:0] addr_q [$];
    logic [1:0]  done_q [$];
    logic [11:0] pxl_q  [$];
    string       name_q [$];

    logic chk_en = 1'b0;
    logic chk_d  = 1'b0;
    always @(posedge clk) chk_d <= chk_en;

    logic [11:0] m_addr;
    logic [1:0]  m_done;
    logic [11:0] m_pxl;
    string       m_name;

    always @(negedge clk) begin
        if (rstn) begin
            if (fen) begin
                vecs++;
                if (addr_q.size() == 0) begin
                    errs++;
                    $display("FAIL rd_addr: unexpected read addr=%0d", faddr);
                end else begin
                    m_addr = addr_q.pop_front();
                    if (faddr !== m_addr) begin
                        errs++;
                        $display("FAIL rd_addr: got %0d want %0d", faddr, m_addr);
                    end
                end
            end
            if (dut.fill_done != 2'b00) begin
                vecs++;
                if (done_q.size() == 0) begin
                    errs++;
                    $display("FAIL fill_done: unexpected %b", dut.fill_done);
                end else begin
                    m_done = done_q.pop_front();
                    if (dut.fill_done !== m_done) begin
                        errs++;
                        $display("FAIL fill_done: got %b want %b",
                                 dut.fill_done, m_done);
                    end
                end
            end
            if (chk_d) begin
                vecs++;
                m_pxl  = pxl_q.pop_front();
                m_name = name_q.pop_front();
                if (disp !== m_pxl) begin
                    errs++;
                    $display("FAIL %s: got %h want %h", m_name, disp, m_pxl);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input int l, input int p);
        ln     = 10'(l);
        pxl    = 10'(p);
        chk_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input int l, input int p, input logic [11:0] e,
                            input string nm);
        ln     = 10'(l);
        pxl    = 10'(p);
        chk_en = 1'b1;
        pxl_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    int tb_ptr  = 0;
    int tb_disp = 0;

    task automatic push_fill(input int b);
        for (int i = 0; i < 32; i++) begin
            addr_q.push_back(12'(tb_ptr));
            tb_ptr = (tb_ptr + 1) % 3840;
        end
        done_q.push_back(b == 0 ? 2'b01 : 2'b10);
    endtask

    task automatic run_line(input int l);
        if (l == 0) begin
            tb_ptr  = 0;
            tb_disp = 0;
            push_fill(0);
            push_fill(1);
        end else if (l >= 39 && l <= 514 && (l - 35) % 4 == 0) begin
            push_fill(tb_disp);
            tb_disp ^= 1;
        end
        for (int p = 0; p < 80; p++)
            step(l, p);
    endtask

    bit found;

    initial begin
        rstn  = 1'b0;
        ln    = '0;
        pxl   = '0;
        fdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en",   32'(fen), 32'h0);
        check("rst_addr", 32'(faddr), 32'h0);
        check("rst_disp", 32'(disp), 32'h0);
        check("rst_sel",  32'(dut.buff_sel), 32'h1);
        check("rst_req",  32'(dut.fill_req), 32'h0);

        // pre-fill interrupted by reset on the 11th read of buffer 1
        rstn = 1'b1;
        push_fill(0);
        push_fill(1);
        step(0, 0);
        found = 1'b0;
        for (int p = 1; p < 200 && !found; p++) begin
            if (fen && faddr == 12'd42) found = 1'b1;
            else step(0, p);
        end
        check("abort_seen", 32'(found), 32'h1);
        rstn = 1'b0;
        #1;
        check("abort_en",  32'(fen), 32'h0);
        check("abort_sel", 32'(dut.buff_sel), 32'h1);
        check("abort_req", 32'(dut.fill_req), 32'h0);
        addr_q.delete();
        done_q.delete();
        repeat (3) @(posedge clk);
        #1;
        ln   = 10'd10;
        pxl  = 10'd5;
        rstn = 1'b1;
        for (int p = 5; p < 25; p++) step(10, p);
        check("idle_en", 32'(fen), 32'h0);

        // full frame (shortened lines) including the wrapping refill
        for (int l = 0; l < 525; l++) begin
            run_line(l);
            if (l == 35) begin
                for (int p = 144; p < 148; p++)
                    step_chk(35, p, 12'h000, "l35_t0");
                step_chk(35, 164, 12'h111, "l35_t5");
                step_chk(35, 783, 12'hFFF, "l35_t159");
                step_chk(35, 100, 12'h000, "l35_hblank");
            end
            if (l == 39) begin
                check("l39_sel", 32'(dut.buff_sel), 32'h2);
                step_chk(39, 144, 12'h000, "l39_t0");
                step_chk(39, 224, exp_pxl(1, 20), "l39_t20");
            end
            if (l == 43) begin
                step_chk(43, 164, exp_pxl(2, 5), "l43_t5");
                step_chk(43, 783, exp_pxl(2, 159), "l43_t159");
            end
            if (l == 514)
                step_chk(514, 200, exp_pxl(119, 14), "l514_t14");
            if (l == 520)
                step_chk(520, 164, BLANK ? 12'h000 : exp_pxl(119, 5),
                         "l520_vblank");
        end

        // next frame: pre-fill restarts at address 0
        for (int l = 0; l < 36; l++) run_line(l);
        step_chk(35, 164, exp_pxl(0, 5), "f2_l35_t5");
        step_chk(35, 783, exp_pxl(0, 159), "f2_l35_t159");
        for (int p = 0; p < 10; p++) step(36, p);

        check("addr_q_empty", 32'(addr_q.size()), 32'h0);
        check("done_q_empty", 32'(done_q.size()), 32'h0);
        check("pxl_q_empty",  32'(pxl_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
